fizzbuzz_seq: RTL
=================

# fizzbuzz_seq

Sequencer for the fizzbuzz datapath. On a start command it walks values 1..limit and emits one classified token per value on a valid/ready output stream: number, fizz, buzz or fizzbuzz. It sits between a host/control interface and any downstream consumer (display, checker, log). It owns the counting, backpressure and completion signalling that the bare fizzbuzz classifier lacks.

## Interface

- `W`, default 8: width of `limit` and `out_value`.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: start request, sampled only in IDLE.
- `limit`, in, W: last value to emit, inclusive; sampled with `start`.
- `abort`, in, 1: terminates a run in progress.
- `out_valid`, out, 1: a token is presented.
- `out_ready`, in, 1: the consumer accepts the token.
- `out_value`, out, W: current value.
- `out_class`, out, 2: token class. 0 = number, 1 = fizz (value divisible by 3 only), 2 = buzz (divisible by 5 only), 3 = fizzbuzz (divisible by 15).
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse on normal completion.

## Operation

- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `start` = 1 with `limit` != 0: latch `limit`, load value = 1, mod3 = 1, mod5 = 1, go to RUN.
  - `start` = 1 with `limit` = 0: go straight to DONE; no tokens are emitted.
- **RUN**
  - `out_valid` = 1 and `busy` = 1.
  - Handshake occurs when `out_valid` and `out_ready` are both high.
  - On a handshake with value != limit: value += 1. mod3 wraps 2 -> 0 and mod5 wraps 4 -> 0.
  - On a handshake with value == limit: go to DONE.
- **DONE**
  - `done` = 1 and `out_valid` = 0, for one cycle only; then return to IDLE.
  - `start` is ignored in this state.
- **Classification**
  - Derived from the residue counters only; no divider.
  - `out_class` = {mod5 == 0, mod3 == 0}.
- **Holding rule:** while `out_valid` = 1 and `out_ready` = 0, `out_value` and `out_class` are held stable.
- **Abort**
  - `abort` = 1 in RUN: go to IDLE at the next edge. `out_valid` and `busy` drop; no `done` pulse.
  - If a handshake occurs in the same cycle as `abort`, the beat counts as transferred.
  - `abort` outside RUN is ignored.
- **Start while busy:** `start` asserted in RUN or DONE is ignored; it is not queued.
- **No wrap:** value never wraps, because the run ends at `limit` ≤ 2^W−1. `limit` = 2^W−1 is legal.
- **Output encoding when `out_valid` = 0:** `out_value` and `out_class` are don't-care for the consumer. The implementation drives 0 in IDLE.

## Timing

- **Reset values** (`resetn` low, asynchronous): state = IDLE, `out_valid` = 0, `out_value` = 0, `out_class` = 0, `busy` = 0, `done` = 0.
- **Reset during RUN:** the run is lost. Outputs take their reset values immediately, with no `done` pulse.
- **Start latency:** `start` sampled at edge N gives `out_valid` = 1 and `busy` = 1 from edge N (registered, visible in cycle N+1). The token carries value 1.
- **Throughput:** one token per cycle while `out_ready` is held high.
- **Completion:** last handshake at edge M gives `busy` = 0 and `done` = 1 in cycle M+1, then `done` = 0 in cycle M+2. A new `start` is accepted from cycle M+2.
- **Zero limit:** `start` with `limit` = 0 at edge N gives `done` = 1 in cycle N+1 and `busy` = 0 throughout.
- **Abort latency:** `abort` sampled at edge N gives `out_valid` = 0 and `busy` = 0 in cycle N+1.
- **Registered outputs:** all outputs are registered. `out_valid` must not combinationally depend on `out_ready`.

## Test plan

- **Basic run:** `limit` = 15, `out_ready` tied high.
  - 15 tokens arrive in consecutive cycles.
  - Classes per value: 3/6/9/12 = 1, 5/10 = 2, 15 = 3, all others = 0.
  - `done` is high for exactly 1 cycle, one cycle after the value-15 beat.
- **Backpressure:** `limit` = 10, `out_ready` pseudo-random at about 50%.
  - Exactly 10 accepted beats, values 1..10 in order with no duplicates or skips.
  - `out_value` and `out_class` are stable across every stalled cycle.
- **Zero limit and ignored start:** `start` with `limit` = 0 gives a `done` pulse with no `out_valid`. A second `start` during a `limit` = 5 run is ignored: exactly 5 beats and one `done`.
- **Abort:** `limit` = 20, `abort` asserted on the cycle value 7 is presented with `out_ready` = 1.
  - Value 7 is accepted.
  - `out_valid` = 0 next cycle, no `done` pulse, state returns to IDLE.
  - A new `start` then restarts from value 1.
- **Reset mid-run:** `resetn` pulled low during a run at value 4.
  - All outputs read 0 immediately.
  - After release, `out_valid` stays 0 until the next `start`.
- **Full range:** W = 8, `limit` = 255.
  - 255 beats; the last beat is value 255 with class 3.
  - No wrap to 0; the residue counters stay consistent with value mod 3 and mod 5 throughout.

Source files
------------

// File: rtl/fizzbuzz_seq.sv
`default_nettype none
// ============================================================================
// Module   : fizzbuzz_seq
// Brief    : Walks 1..limit and streams one fizz/buzz-classified token per
//            value over a valid/ready interface, with abort and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fizzbuzz_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] limit,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_value,
    output logic [1:0]   out_class,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] value_q, value_d;
    logic [W-1:0] limit_q, limit_d;
    logic [1:0]   mod3_q,  mod3_d;
    logic [2:0]   mod5_q,  mod5_d;
    logic         valid_q, valid_d;
    logic         done_q,  done_d;

    logic         w_handshake;

    assign w_handshake = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        limit_d = limit_q;
        mod3_d  = mod3_q;
        mod5_d  = mod5_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (limit != '0) begin
                        state_d = RUN;
                        limit_d = limit;
                        value_d = {{(W-1){1'b0}}, 1'b1};
                        mod3_d  = 2'd1;
                        mod5_d  = 3'd1;
                        valid_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort wins over completion; a beat accepted alongside it still counts.
                if (abort || (w_handshake && value_q == limit_q)) begin
                    state_d = abort ? IDLE : DONE;
                    done_d  = !abort;
                    valid_d = 1'b0;
                    value_d = '0;
                    mod3_d  = 2'd1;
                    mod5_d  = 3'd1;
                end else if (w_handshake) begin
                    value_d = value_q + {{(W-1){1'b0}}, 1'b1};
                    mod3_d  = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
                    mod5_d  = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                value_d = '0;
                mod3_d  = 2'd1;
                mod5_d  = 3'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            value_q <= '0;
            limit_q <= '0;
            mod3_q  <= 2'd1;
            mod5_q  <= 3'd1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            limit_q <= limit_d;
            mod3_q  <= mod3_d;
            mod5_q  <= mod5_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Residues idle at 1 so the class reads 0 whenever no token is presented.
    assign out_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;
    assign out_value = value_q;
    assign out_class = {mod5_q == 3'd0, mod3_q == 2'd0};

endmodule
`default_nettype wire
